gsensor_spi_responder: RTL and testbench

//  Synthesizable SPI target that emulates the ADXL345 accelerometer at the far end of the G-sensor bus.
//  It lets the SPI master controller be exercised in simulation and on-board loopback without the real part.

---
 rtl/gsensor_spi_responder.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_gsensor_spi_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsensor_spi_responder.sv
// rtl/gsensor_spi_responder.sv - ADXL345-style SPI target emulator for the G-sensor bus
//
// Purpose: a mode-3 SPI target that answers like an ADXL345. It serves DEVID,
// a small set of writable config registers and the six data registers, which
// are loaded from the sample ports. The SPI pins are oversampled in iCLK.
//
// Optional feature macro: ADXL_INT_EN (DATA_READY flag in INT_SOURCE and the
// oINT2 pin). When the macro is undefined, 0x30 reads 0x00 and oINT2 is tied 0.
//
// Ports:
//   iCLK, iRST               system clock, asynchronous active-high reset
//   iSPI_CLK/CSN/SDI         SPI pins from the master (raw, asynchronous)
//   oSPI_SDO, oSDO_OE        target data out and its output enable
//   iDATA_X/Y/Z, iSAMPLE_STB sample input and its 1-cycle valid strobe
//   oREG_WE/ADDR/WDATA       1-cycle notification of a committed register write
//   oBUSY                    synchronized chip select is asserted
//   oINT2                    emulated INT2 pin, active-high
module gsensor_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_VAL   = 8'hE5
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSPI_CLK,
  input  logic        iSPI_CSN,
  input  logic        iSPI_SDI,
  output logic        oSPI_SDO,
  output logic        oSDO_OE,
  input  logic [15:0] iDATA_X,
  input  logic [15:0] iDATA_Y,
  input  logic [15:0] iDATA_Z,
  input  logic        iSAMPLE_STB,
  output logic        oREG_WE,
  output logic [5:0]  oREG_ADDR,
  output logic [7:0]  oREG_WDATA,
  output logic        oBUSY,
  output logic        oINT2
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Pin synchronizers. SCLK and CSN reset to their idle-high levels so that
  // leaving reset never looks like an edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, csn_s, sdi_s;
  logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sclk_sync_q <= '1;
      csn_sync_q  <= '1;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b1;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], iSPI_CLK};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], iSPI_CSN};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], iSPI_SDI};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;

  // Transaction state
  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shin_q, shin_d;
  logic       rw_q, rw_d, mb_q, mb_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] shout_q, shout_d;
  logic       load_q, load_d;
  logic       sdo_q, sdo_d, oe_q, oe_d;
  logic       we_q, we_d;
  logic [5:0] we_addr_q, we_addr_d;
  logic [7:0] we_data_q, we_data_d;
  logic [7:0] full_byte;
  logic [7:0] rd_byte;
  logic [7:0] int_src;

  // Register file
  logic [7:0]  ofsx_q, ofsy_q, ofsz_q, bw_rate_q, power_ctl_q;
  logic [7:0]  int_enable_q, int_map_q, data_format_q, fifo_ctl_q;
  logic [15:0] dx_q, dy_q, dz_q, px_q, py_q, pz_q;
  logic        pend_q;
  logic        load_stb, load_pend;

  function automatic logic is_writable(input logic [5:0] a);
    case (a)
      6'h1E, 6'h1F, 6'h20, 6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h31, 6'h38: is_writable = 1'b1;
      default: is_writable = 1'b0;
    endcase
  endfunction

  // The byte completing on the current rise: seven shifted bits plus SDI now.
  assign full_byte = {shin_q, sdi_s};

  always_comb begin
    rd_byte = 8'h00;
    case (addr_q)
      6'h00: rd_byte = DEVID_VAL;
      6'h1E: rd_byte = ofsx_q;
      6'h1F: rd_byte = ofsy_q;
      6'h20: rd_byte = ofsz_q;
      6'h2C: rd_byte = bw_rate_q;
      6'h2D: rd_byte = power_ctl_q;
      6'h2E: rd_byte = int_enable_q;
      6'h2F: rd_byte = int_map_q;
      6'h30: rd_byte = int_src;
      6'h31: rd_byte = data_format_q;
      6'h32: rd_byte = dx_q[7:0];
      6'h33: rd_byte = dx_q[15:8];
      6'h34: rd_byte = dy_q[7:0];
      6'h35: rd_byte = dy_q[15:8];
      6'h36: rd_byte = dz_q[7:0];
      6'h37: rd_byte = dz_q[15:8];
      6'h38: rd_byte = fifo_ctl_q;
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shin_d    = shin_q;
    rw_d      = rw_q;
    mb_d      = mb_q;
    addr_d    = addr_q;
    shout_d   = shout_q;
    load_d    = load_q;
    sdo_d     = sdo_q;
    oe_d      = oe_q;
    we_d      = 1'b0;
    we_addr_d = we_addr_q;
    we_data_d = we_data_q;
    // CSN rise wins over any SCLK edge seen in the same cycle, so a partial
    // byte is simply dropped.
    if (csn_rise && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      sdo_d   = 1'b0;
      load_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          oe_d  = 1'b0;
          sdo_d = 1'b0;
          if (csn_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            shin_d    = full_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d    = full_byte[7];
              mb_d    = full_byte[6];
              addr_d  = full_byte[5:0];
              load_d  = full_byte[7];
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // load_q marks the first fall of a read byte: fetch the register
          // then, so a write or sample update just before is reflected.
          if (sclk_fall && rw_q) begin
            oe_d = 1'b1;
            if (load_q) begin
              sdo_d   = rd_byte[7];
              shout_d = {rd_byte[6:0], 1'b0};
              load_d  = 1'b0;
            end else begin
              sdo_d   = shout_q[7];
              shout_d = {shout_q[6:0], 1'b0};
            end
          end
          if (sclk_rise) begin
            shin_d    = full_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!rw_q && is_writable(addr_q)) begin
                we_d      = 1'b1;
                we_addr_d = addr_q;
                we_data_d = full_byte;
              end
              if (rw_q) load_d = 1'b1;
              if (mb_q) addr_d = addr_q + 6'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shin_q    <= '0;
      rw_q      <= 1'b0;
      mb_q      <= 1'b0;
      addr_q    <= '0;
      shout_q   <= '0;
      load_q    <= 1'b0;
      sdo_q     <= 1'b0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      we_addr_q <= '0;
      we_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shin_q    <= shin_d;
      rw_q      <= rw_d;
      mb_q      <= mb_d;
      addr_q    <= addr_d;
      shout_q   <= shout_d;
      load_q    <= load_d;
      sdo_q     <= sdo_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      we_addr_q <= we_addr_d;
      we_data_q <= we_data_d;
    end
  end

  // Config registers commit on the same cycle the write pulse is raised.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ofsx_q        <= 8'h00;
      ofsy_q        <= 8'h00;
      ofsz_q        <= 8'h00;
      bw_rate_q     <= 8'h0A;
      power_ctl_q   <= 8'h00;
      int_enable_q  <= 8'h00;
      int_map_q     <= 8'h00;
      data_format_q <= 8'h00;
      fifo_ctl_q    <= 8'h00;
    end else if (we_d) begin
      case (addr_q)
        6'h1E: ofsx_q        <= full_byte;
        6'h1F: ofsy_q        <= full_byte;
        6'h20: ofsz_q        <= full_byte;
        6'h2C: bw_rate_q     <= full_byte;
        6'h2D: power_ctl_q   <= full_byte;
        6'h2E: int_enable_q  <= full_byte;
        6'h2F: int_map_q     <= full_byte;
        6'h31: data_format_q <= full_byte;
        6'h38: fifo_ctl_q    <= full_byte;
        default: ;
      endcase
    end
  end

  // Sample coherency: a strobe while CSN is asserted is parked and applied on
  // the CSN-rise cycle. csn_s is already high on that cycle, so a strobe
  // arriving together with the rise takes the direct path and wins.
  assign load_stb  = iSAMPLE_STB & csn_s;
  assign load_pend = csn_rise & pend_q & ~load_stb;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      dx_q   <= '0;
      dy_q   <= '0;
      dz_q   <= '0;
      px_q   <= '0;
      py_q   <= '0;
      pz_q   <= '0;
      pend_q <= 1'b0;
    end else if (load_stb) begin
      dx_q   <= iDATA_X;
      dy_q   <= iDATA_Y;
      dz_q   <= iDATA_Z;
      pend_q <= 1'b0;
    end else if (load_pend) begin
      dx_q   <= px_q;
      dy_q   <= py_q;
      dz_q   <= pz_q;
      pend_q <= 1'b0;
    end else if (iSAMPLE_STB) begin
      px_q   <= iDATA_X;
      py_q   <= iDATA_Y;
      pz_q   <= iDATA_Z;
      pend_q <= 1'b1;
    end
  end

`ifdef ADXL_INT_EN
  logic flag_q, int2_q;
  logic sample_load, rd_clr;

  assign sample_load = load_stb | load_pend;
  assign rd_clr = (state_q == ST_DATA) && !csn_rise && sclk_rise && (bit_cnt_q == 3'd7) &&
                  rw_q && (addr_q >= 6'h32) && (addr_q <= 6'h37);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      flag_q <= 1'b0;
      int2_q <= 1'b0;
    end else begin
      if (sample_load)  flag_q <= 1'b1;
      else if (rd_clr)  flag_q <= 1'b0;
      int2_q <= flag_q & int_enable_q[7] & int_map_q[7];
    end
  end

  assign int_src = {flag_q, 7'd0};
  assign oINT2   = int2_q;
`else
  assign int_src = 8'h00;
  assign oINT2   = 1'b0;
`endif

  assign oSPI_SDO   = sdo_q;
  assign oSDO_OE    = oe_q;
  assign oREG_WE    = we_q;
  assign oREG_ADDR  = we_addr_q;
  assign oREG_WDATA = we_data_q;
  assign oBUSY      = ~csn_s;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// tb/tb_gsensor_spi_responder.sv - randomized model-checked bench for gsensor_spi_responder
`timescale 1ns/1ps
module tb_gsensor_spi_responder;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, csn, sdi;
  logic        sdo, sdo_oe;
  logic [15:0] dxi, dyi, dzi;
  logic        stb;
  logic        reg_we;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        busy, int2;

  gsensor_spi_responder dut (
    .iCLK(clk), .iRST(rst), .iSPI_CLK(sclk), .iSPI_CSN(csn), .iSPI_SDI(sdi),
    .oSPI_SDO(sdo), .oSDO_OE(sdo_oe), .iDATA_X(dxi), .iDATA_Y(dyi), .iDATA_Z(dzi),
    .iSAMPLE_STB(stb), .oREG_WE(reg_we), .oREG_ADDR(reg_addr), .oREG_WDATA(reg_wdata),
    .oBUSY(busy), .oINT2(int2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: register image, current and pending samples, flag.
  logic [7:0]  mreg [64];
  logic [15:0] mx, my, mz, pxm, pym, pzm;
  logic        mpend, mflag;
  logic [13:0] wq [$];
  logic [7:0]  rxbuf [8];
  logic [7:0]  wbuf  [8];
  logic [15:0] sx, sy, sz;

  function automatic logic m_wr_ok(input logic [5:0] a);
    return a inside {6'h1E, 6'h1F, 6'h20, 6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h31, 6'h38};
  endfunction

  function automatic logic [7:0] m_rd(input logic [5:0] a);
    if (a == 6'h00) return 8'hE5;
`ifdef ADXL_INT_EN
    if (a == 6'h30) return {mflag, 7'd0};
`endif
    if (a >= 6'h32 && a <= 6'h37) begin
      logic [47:0] s;
      s = {mz, my, mx};
      return s[(a - 6'h32) * 8 +: 8];
    end
    if (m_wr_ok(a)) return mreg[a];
    return 8'h00;
  endfunction

  function automatic logic m_int();
`ifdef ADXL_INT_EN
    return mflag & mreg[6'h2E][7] & mreg[6'h2F][7];
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
    mreg[6'h2C] = 8'h0A;
    mx = 0; my = 0; mz = 0; pxm = 0; pym = 0; pzm = 0;
    mpend = 1'b0; mflag = 1'b0;
  endtask

  task automatic do_stb(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    dxi = x; dyi = y; dzi = z; stb = 1'b1;
    if (csn == 1'b0) begin
      pxm = x; pym = y; pzm = z; mpend = 1'b1;
    end else begin
      mx = x; my = y; mz = z; mflag = 1'b1; mpend = 1'b0;
    end
    #10;
    stb = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0; sdi = tx[7-i];
      #HALF;
      sclk = 1'b1; rx[7-i] = sdo;
      #HALF;
    end
  endtask

  task automatic spi_end();
    csn = 1'b1;
    if (mpend) begin
      mx = pxm; my = pym; mz = pzm; mflag = 1'b1; mpend = 1'b0;
    end
    #120;
  endtask

  // One CSN-framed transaction: command, nbytes full bytes, optional partial
  // byte of part_bits, optional strobe just before data byte stb_at.
  task automatic spi_txn(input logic rw, input logic mb, input logic [5:0] a,
                         input int nbytes, input int part_bits, input int stb_at);
    logic [7:0] rx, e;
    logic [5:0] ad;
    ad = a;
    csn = 1'b0;
    #HALF;
    spi_bits({rw, mb, a}, 8, rx);
    for (int b = 0; b < nbytes; b++) begin
      if (b == stb_at) do_stb(sx, sy, sz);
      if (rw) begin
        e = m_rd(ad);
        spi_bits(8'h00, 8, rx);
        rxbuf[b] = rx;
        chk($sformatf("read@%02h", ad), 32'(rx), 32'(e));
        if (ad >= 6'h32 && ad <= 6'h37) mflag = 1'b0;
      end else begin
        if (m_wr_ok(ad)) begin
          wq.push_back({ad, wbuf[b]});
          mreg[ad] = wbuf[b];
        end
        spi_bits(wbuf[b], 8, rx);
      end
      if (mb) ad = ad + 6'd1;
    end
    if (part_bits > 0) spi_bits(rw ? 8'h00 : wbuf[nbytes], part_bits, rx);
    spi_end();
  endtask

  // Per-cycle compare process.
  int          hi_cnt = 0, lo_cnt = 0, since_stb = 0;
  int          we_cnt = 0;
  logic [13:0] last_we = '0;

  always @(posedge clk) begin
    if (rst) begin
      hi_cnt = 0; lo_cnt = 0; since_stb = 0;
    end else begin
      if (csn) begin hi_cnt++; lo_cnt = 0; end
      else     begin lo_cnt++; hi_cnt = 0; end
      if (stb) since_stb = 0;
      else if (since_stb < 1000) since_stb++;
    end
    #1;
    if (!rst) begin
      if (lo_cnt >= 4) chk("busy_low_csn", 32'(busy), 32'd1);
      if (hi_cnt >= 4) begin
        chk("busy_idle", 32'(busy), 32'd0);
        chk("oe_idle", 32'(sdo_oe), 32'd0);
        chk("sdo_idle", 32'(sdo), 32'd0);
      end
      if (hi_cnt >= 8 && since_stb >= 8) chk("int2", 32'(int2), 32'(m_int()));
      if (reg_we) begin
        we_cnt++;
        last_we = {reg_addr, reg_wdata};
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_we got %0h expected none", {reg_addr, reg_wdata});
        end else begin
          chk("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(wq.pop_front()));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0]  burst_exp [6];
  logic [5:0]  cfg_addr  [9];

  initial begin
    int          c0, nb, pb, sa;
    logic [5:0]  ra;
    logic        rrw, rmb;
    logic [7:0]  rx;

    burst_exp = '{8'h23, 8'h01, 8'hDC, 8'hFE, 8'h01, 8'h80};
    cfg_addr  = '{6'h1E, 6'h1F, 6'h20, 6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h31, 6'h38};
    rst = 1'b1; csn = 1'b1; sclk = 1'b1; sdi = 1'b0; stb = 1'b0;
    dxi = 0; dyi = 0; dzi = 0; sx = 0; sy = 0; sz = 0;
    m_reset();
    for (int k = 0; k < 8; k++) wbuf[k] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_oe", 32'(sdo_oe), 32'd0);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_we", 32'(reg_we), 32'd0);
    chk("rst_addr_data", 32'({reg_addr, reg_wdata}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_int2", 32'(int2), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // DEVID
    spi_txn(1'b1, 1'b0, 6'h00, 1, 0, -1);
    chk("devid", 32'(rxbuf[0]), 32'hE5);

    // Multi-byte burst of a fresh sample
    do_stb(16'h0123, 16'hFEDC, 16'h8001);
    #80;
    spi_txn(1'b1, 1'b1, 6'h32, 6, 0, -1);
    for (int k = 0; k < 6; k++) chk("burst_lit", 32'(rxbuf[k]), 32'(burst_exp[k]));

    // Address wrap 0x3F -> 0x00
    spi_txn(1'b1, 1'b1, 6'h3F, 2, 0, -1);
    chk("wrap_3f", 32'(rxbuf[0]), 32'h00);
    chk("wrap_00", 32'(rxbuf[1]), 32'hE5);

    // Write to POWER_CTL, then a dropped write to a data register
    c0 = we_cnt;
    wbuf[0] = 8'h08;
    spi_txn(1'b0, 1'b0, 6'h2D, 1, 0, -1);
    chk("we_count_one", 32'(we_cnt), 32'(c0 + 1));
    chk("we_last", 32'(last_we), 32'({6'h2D, 8'h08}));
    spi_txn(1'b1, 1'b0, 6'h2D, 1, 0, -1);
    chk("power_ctl_rb", 32'(rxbuf[0]), 32'h08);
    c0 = we_cnt;
    wbuf[0] = 8'h55;
    spi_txn(1'b0, 1'b0, 6'h32, 1, 0, -1);
    chk("ro_write_no_we", 32'(we_cnt), 32'(c0));
    spi_txn(1'b1, 1'b0, 6'h32, 1, 0, -1);
    chk("ro_write_rb", 32'(rxbuf[0]), 32'h23);

    // Coherency: strobe mid-burst applies only after CSN rises
    sx = 16'h1111; sy = 16'h2222; sz = 16'h3333;
    spi_txn(1'b1, 1'b1, 6'h32, 6, 0, 2);
    for (int k = 0; k < 6; k++) chk("coherent_old", 32'(rxbuf[k]), 32'(burst_exp[k]));
    spi_txn(1'b1, 1'b1, 6'h32, 2, 0, -1);
    chk("coherent_new_lo", 32'(rxbuf[0]), 32'h11);
    chk("coherent_new_hi", 32'(rxbuf[1]), 32'h11);

    // Partial write byte is discarded
    c0 = we_cnt;
    wbuf[0] = 8'hAA;
    spi_txn(1'b0, 1'b0, 6'h2D, 0, 5, -1);
    chk("partial_no_we", 32'(we_cnt), 32'(c0));
    spi_txn(1'b1, 1'b0, 6'h2D, 1, 0, -1);
    chk("partial_rb", 32'(rxbuf[0]), 32'h08);

    // Interrupt
`ifdef ADXL_INT_EN
    wbuf[0] = 8'h80;
    spi_txn(1'b0, 1'b0, 6'h2E, 1, 0, -1);
    spi_txn(1'b0, 1'b0, 6'h2F, 1, 0, -1);
    do_stb(16'h0A0B, 16'h0C0D, 16'h0E0F);
    #100;
    chk("int2_set", 32'(int2), 32'd1);
    spi_txn(1'b1, 1'b0, 6'h32, 1, 0, -1);
    chk("int2_clr", 32'(int2), 32'd0);
    do_stb(16'h1A1B, 16'h1C1D, 16'h1E1F);
    #100;
    chk("int2_reset", 32'(int2), 32'd1);
`else
    do_stb(16'h0A0B, 16'h0C0D, 16'h0E0F);
    #100;
    chk("int2_off", 32'(int2), 32'd0);
    spi_txn(1'b1, 1'b0, 6'h30, 1, 0, -1);
    chk("int_src_off", 32'(rxbuf[0]), 32'h00);
`endif

    // SCLK toggling with CSN high is ignored
    for (int k = 0; k < 6; k++) begin
      sclk = ~sclk; sdi = ~sdi;
      #HALF;
    end
    sclk = 1'b1;
    #80;
    spi_txn(1'b1, 1'b0, 6'h00, 1, 0, -1);
    chk("devid_after_idle_clk", 32'(rxbuf[0]), 32'hE5);

    // Reset in the middle of a read
    wbuf[0] = 8'h0F;
    spi_txn(1'b0, 1'b0, 6'h2C, 1, 0, -1);
    csn = 1'b0;
    #HALF;
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h00, 3, rx);
    chk("oe_mid_read", 32'(sdo_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("oe_at_reset", 32'(sdo_oe), 32'd0);
    #9;
    csn = 1'b1; sclk = 1'b1;
    m_reset();
    wq.delete();
    #50;
    rst = 1'b0;
    #100;
    spi_txn(1'b1, 1'b0, 6'h2C, 1, 0, -1);
    chk("bw_rate_after_reset", 32'(rxbuf[0]), 32'h0A);

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: ra = 6'h32 + 6'($urandom_range(0, 5));
        1: ra = cfg_addr[$urandom_range(0, 8)];
        2: ra = 6'($urandom_range(0, 63));
        default: ra = ($urandom_range(0, 1) != 0) ? 6'h30 : 6'h3E;
      endcase
      rrw = 1'($urandom_range(0, 1));
      rmb = 1'($urandom_range(0, 1));
      nb  = int'($urandom_range(1, 4));
      pb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      sa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
      if ($urandom_range(0, 1) != 0) begin
        do_stb(16'($urandom), 16'($urandom), 16'($urandom));
        #80;
      end
      sx = 16'($urandom); sy = 16'($urandom); sz = 16'($urandom);
      spi_txn(rrw, rmb, ra, nb, pb, sa);
    end

    #200;
    chk("we_queue_empty", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
